instr_encoder_loader: RTL and testbench

//  Reverse of the main decoder: takes symbolic instruction fields over a valid/ready stream,

---
 rtl/instr_encoder_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Encodes symbolic MIPS instruction fields, received over a valid/ready stream,
//   into 32-bit machine words. It writes the words one after another into
//   instruction memory, starting at BASE. Boot or bench logic uses it to fill
//   program memory before the CPU runs.
//   Supported subset: ADD SUB SLT JR ADDI SLTI LW SW J JAL BEQ BNE.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on the FSM state, so it never depends on in_valid.
//   The producer may hold in_valid high while it waits.
//
// Optional feature (macro INSTR_LOADER_VERIFY_EN):
//   - Adds the ports mem_re, mem_rdata and mismatch.
//   - Each written word is read back (READ) and compared (CHECK) before the
//     address advances.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   start                       open a session (honoured only in IDLE)
//   in_valid / in_ready         beat handshake
//   in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last
//                               beat payload
//   mem_addr, mem_wdata, mem_we memory write port (byte address)
//   busy, done                  status; done is a one-cycle pulse
//   count                       words written this session
//   err                         sticky [0] illegal kind, [1] overflow
//   dbgState                    current FSM state, for checkers
//   mem_re, mem_rdata, mismatch readback port (VERIFY_EN only)
module instr_encoder_loader #(
    parameter int          ADDR_W = 32,
    parameter int unsigned BASE   = 0,
    parameter int          DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
`ifdef INSTR_LOADER_VERIFY_EN
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mismatch,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    output logic [1:0]        err,
    output logic [2:0]        dbgState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } loaderState;

    localparam logic [ADDR_W-1:0] baseAddr  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] depthW    = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] wordBytes = ADDR_W'(4);

    localparam logic [5:0] FUNC_ADD = 6'd32;
    localparam logic [5:0] FUNC_SUB = 6'd34;
    localparam logic [5:0] FUNC_SLT = 6'd42;
    localparam logic [5:0] FUNC_JR  = 6'd8;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    loaderState        state;
    loaderState        stateNext;
    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W-1:0] countReg;
    logic [1:0]        errReg;
    logic [31:0]       wordReg;
    logic              lastReg;
    logic              writeReg;  // beat being processed produces a memory write
    logic [31:0]       encWord;
    logic              encLegal;
    logic              full;
`ifdef INSTR_LOADER_VERIFY_EN
    logic              mismatchReg;
`endif

    // Field encoder, working on the raw input beat.
    always_comb begin
        encWord  = '0;
        encLegal = 1'b1;
        case (in_kind)
            4'd0:  encWord = {6'd0, in_rs, in_rt, in_rd, 5'd0, FUNC_ADD};
            4'd1:  encWord = {6'd0, in_rs, in_rt, in_rd, 5'd0, FUNC_SUB};
            4'd2:  encWord = {6'd0, in_rs, in_rt, in_rd, 5'd0, FUNC_SLT};
            4'd3:  encWord = {6'd0, in_rs, 5'd0, 5'd0, 5'd0, FUNC_JR};
            4'd4:  encWord = {OP_ADDI, in_rs, in_rt, in_imm};
            4'd5:  encWord = {OP_SLTI, in_rs, in_rt, in_imm};
            4'd6:  encWord = {OP_LW, in_rs, in_rt, in_imm};
            4'd7:  encWord = {OP_SW, in_rs, in_rt, in_imm};
            4'd8:  encWord = {OP_J, in_target};
            4'd9:  encWord = {OP_JAL, in_target};
            4'd10: encWord = {OP_BEQ, in_rs, in_rt, in_imm};
            4'd11: encWord = {OP_BNE, in_rs, in_rt, in_imm};
            default: encLegal = 1'b0;
        endcase
    end

    assign full = (countReg == depthW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addrReg  <= baseAddr;
            countReg <= '0;
            errReg   <= '0;
            wordReg  <= '0;
            lastReg  <= 1'b0;
            writeReg <= 1'b0;
`ifdef INSTR_LOADER_VERIFY_EN
            mismatchReg <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        addrReg  <= baseAddr;
                        countReg <= '0;
                        errReg   <= '0;
`ifdef INSTR_LOADER_VERIFY_EN
                        mismatchReg <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        wordReg  <= encWord;
                        lastReg  <= in_last;
                        // Illegal and overflow beats are consumed but never written.
                        writeReg <= encLegal && !full;
                        if (!encLegal) errReg[0] <= 1'b1;
                        if (full)      errReg[1] <= 1'b1;
                    end
                end
`ifdef INSTR_LOADER_VERIFY_EN
                CHECK: begin
                    if (mem_rdata != wordReg) mismatchReg <= 1'b1;
                    addrReg  <= addrReg + wordBytes;
                    countReg <= countReg + 1'b1;
                end
`else
                WRITE: begin
                    if (writeReg) begin
                        addrReg  <= addrReg + wordBytes;
                        countReg <= countReg + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
`ifdef INSTR_LOADER_VERIFY_EN
        mem_re    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) stateNext = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) stateNext = WRITE;
            end
            WRITE: begin
                mem_we = writeReg;
`ifdef INSTR_LOADER_VERIFY_EN
                if (writeReg)     stateNext = READ;
                else if (lastReg) stateNext = DONE;
                else              stateNext = LOAD;
`else
                stateNext = lastReg ? DONE : LOAD;
`endif
            end
`ifdef INSTR_LOADER_VERIFY_EN
            READ: begin
                mem_re    = 1'b1;
                stateNext = CHECK;
            end
            CHECK: begin
                stateNext = lastReg ? DONE : LOAD;
            end
`endif
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign mem_addr  = addrReg;
    assign mem_wdata = wordReg;
    assign count     = countReg;
    assign err       = errReg;
    assign dbgState  = state;
`ifdef INSTR_LOADER_VERIFY_EN
    assign mismatch  = mismatchReg;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader (DEPTH reduced to 2 so overflow is reachable).
module tb_instr_encoder_loader;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic [31:0] count;
    logic [1:0]  err;
    logic [2:0]  dbgState;
`ifdef INSTR_LOADER_VERIFY_EN
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mismatch;
    logic        corruptRead;
    logic [31:0] memArr [0:255];
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];   // {byte address, word} of each expected write
    logic [63:0] monExp;

    // Reference model state for randomized sessions
    int          modelCount;
    logic [1:0]  modelErr;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic        wr;
        logic [31:0] word;
    } vecT;
    vecT vecs [13];

    instr_encoder_loader #(.ADDR_W(32), .BASE(0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
`ifdef INSTR_LOADER_VERIFY_EN
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mismatch(mismatch),
`endif
        .busy(busy), .done(done), .count(count), .err(err), .dbgState(dbgState)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

`ifdef INSTR_LOADER_VERIFY_EN
    // Memory model with optional bit-0 corruption on readback
    always @(posedge clk) begin
        if (mem_we) memArr[mem_addr[9:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= memArr[mem_addr[9:2]] ^ {31'd0, corruptRead};
    end
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard: every write must match the queue head ----------------
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                monExp = exp_q.pop_front();
                check("write", {mem_addr, mem_wdata}, monExp);
            end
        end
    end

    // Reference encoder: arithmetic composition of the instruction fields
    function automatic logic [31:0] refEncode(input int k, input int rs, input int rt, input int rd,
                                              input int imm, input int tgt);
        int op;
        int fn;
        case (k)
            0: fn = 32;
            1: fn = 34;
            2: fn = 42;
            default: fn = 8;
        endcase
        case (k)
            4: op = 8;   5: op = 10;  6: op = 35;  7: op = 43;
            8: op = 2;   9: op = 3;   10: op = 4;  default: op = 5;
        endcase
        if (k <= 2)      return 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + fn);
        else if (k == 3) return 32'(rs * (1 << 21) + 8);
        else if (k == 8 || k == 9) return 32'(op) * 32'h0400_0000 + 32'(tgt);
        else             return 32'(op) * 32'h0400_0000 + 32'(rs * (1 << 21) + rt * (1 << 16) + imm);
    endfunction

    // ---------------- driver tasks (enter and leave on a falling edge) ----------------
    task automatic startSession();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        modelCount = 0;
        modelErr   = 2'b00;
    endtask

    task automatic sendBeat(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                            input logic last);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
            return;
        end
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    // Model one randomized beat and queue its expected write
    task automatic modelBeat(input int k, input int rs, input int rt, input int rd,
                             input int imm, input int tgt);
        if (k >= 12)                modelErr[0] = 1'b1;
        else if (modelCount == DEPTH) modelErr[1] = 1'b1;
        else begin
            exp_q.push_back({32'(modelCount * 4), refEncode(k, rs, rt, rd, imm, tgt)});
            modelCount++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b1, 32'h00221820};
        vecs[1]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0,    26'h0,       1'b1, 32'h00853022};
        vecs[2]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'h0,    26'h0,       1'b1, 32'h00E8482A};
        vecs[3]  = '{4'd3,  5'd31, 5'd5,  5'd6,  16'h0,    26'h0,       1'b1, 32'h03E00008};
        vecs[4]  = '{4'd4,  5'd0,  5'd8,  5'd7,  16'hFFFF, 26'h0,       1'b1, 32'h2008FFFF};
        vecs[5]  = '{4'd5,  5'd2,  5'd3,  5'd0,  16'h0010, 26'h0,       1'b1, 32'h28430010};
        vecs[6]  = '{4'd6,  5'd29, 5'd4,  5'd0,  16'h0008, 26'h0,       1'b1, 32'h8FA40008};
        vecs[7]  = '{4'd7,  5'd29, 5'd31, 5'd0,  16'hFFFC, 26'h0,       1'b1, 32'hAFBFFFFC};
        vecs[8]  = '{4'd8,  5'd0,  5'd0,  5'd0,  16'h0,    26'h10,      1'b1, 32'h08000010};
        vecs[9]  = '{4'd9,  5'd0,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 1'b1, 32'h0FFFFFFF};
        vecs[10] = '{4'd10, 5'd1,  5'd2,  5'd0,  16'h0003, 26'h0,       1'b1, 32'h10220003};
        vecs[11] = '{4'd11, 5'd8,  5'd0,  5'd0,  16'h8000, 26'h0,       1'b1, 32'h15008000};
        vecs[12] = '{4'd12, 5'd1,  5'd1,  5'd1,  16'h1,    26'h1,       1'b0, 32'h0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
`ifdef INSTR_LOADER_VERIFY_EN
        corruptRead = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(dbgState), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---- single ADD, cycle-exact ----
        startSession();
        exp_q.push_back({32'd0, 32'h00221820});
        sendBeat(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
`ifndef INSTR_LOADER_VERIFY_EN
        check("add_we", 64'(mem_we), 64'd1);
        check("add_addr", 64'(mem_addr), 64'd0);
        check("add_wdata", 64'(mem_wdata), 64'h00221820);
        check("add_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("add_done", 64'(done), 64'd1);
        check("add_we_off", 64'(mem_we), 64'd0);
        check("add_count", 64'(count), 64'd1);
        @(negedge clk);
        check("add_done_pulse", 64'(done), 64'd0);
        check("add_idle", 64'(busy), 64'd0);
`else
        waitDone();
        check("add_count", 64'(count), 64'd1);
        @(negedge clk);
`endif

        // ---- ADDI then J, start pulse mid-session ignored ----
        startSession();
        exp_q.push_back({32'd0, 32'h2008FFFF});
        sendBeat(4'd4, 5'd0, 5'd8, 5'd0, 16'hFFFF, 26'h0, 1'b0);
`ifndef INSTR_LOADER_VERIFY_EN
        check("addi_ready_gap", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("addi_ready_back", 64'(in_ready), 64'd1);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back({32'd4, 32'h08000010});
        sendBeat(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
        waitDone();
        check("addij_count", 64'(count), 64'd2);
        check("addij_err", 64'(err), 64'd0);
        @(negedge clk);

        // ---- illegal kind between two LW beats ----
        startSession();
        exp_q.push_back({32'd0, 32'h8C220004});
        exp_q.push_back({32'd4, 32'h8C430008});
        sendBeat(4'd6, 5'd1, 5'd2, 5'd0, 16'h0004, 26'h0, 1'b0);
        sendBeat(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        sendBeat(4'd6, 5'd2, 5'd3, 5'd0, 16'h0008, 26'h0, 1'b1);
        waitDone();
        check("illegal_err", 64'(err), 64'd1);
        check("illegal_count", 64'(count), 64'd2);
        @(negedge clk);

        // ---- overflow: three beats into a two-word session ----
        startSession();
        exp_q.push_back({32'd0, 32'h00221820});
        exp_q.push_back({32'd4, 32'h00853022});
        sendBeat(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        sendBeat(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
        sendBeat(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1);
        waitDone();
        check("ovf_err", 64'(err), 64'd2);
        check("ovf_count", 64'(count), 64'd2);
        @(negedge clk);

        // ---- reset while mem_we is high ----
        startSession();
        exp_q.push_back({32'd0, 32'h00221820});
        sendBeat(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        check("rst_mid_we_before", 64'(mem_we), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_we", 64'(mem_we), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_count", 64'(count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        startSession();
        exp_q.push_back({32'd0, 32'h10220003});
        sendBeat(4'd10, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0, 1'b1);
        waitDone();
        check("restart_count", 64'(count), 64'd1);
        @(negedge clk);

`ifdef INSTR_LOADER_VERIFY_EN
        // ---- readback corruption flags mismatch ----
        startSession();
        corruptRead = 1'b1;
        exp_q.push_back({32'd0, 32'h10220003});
        sendBeat(4'd10, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0, 1'b1);
        waitDone();
        check("verify_mismatch", 64'(mismatch), 64'd1);
        corruptRead = 1'b0;
        @(negedge clk);
        startSession();
        check("verify_cleared", 64'(mismatch), 64'd0);
        exp_q.push_back({32'd0, 32'h10220003});
        sendBeat(4'd10, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0, 1'b1);
        waitDone();
        check("verify_clean", 64'(mismatch), 64'd0);
        @(negedge clk);
`endif

        // ---- encoding table: one single-beat session per entry ----
        for (int i = 0; i < 13; i++) begin
            startSession();
            if (vecs[i].wr) exp_q.push_back({32'd0, vecs[i].word});
            sendBeat(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                     vecs[i].imm, vecs[i].target, 1'b1);
            waitDone();
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].wr));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(!vecs[i].wr));
            @(negedge clk);
        end

        // ---- randomized sessions against the reference model ----
        for (int s = 0; s < 25; s++) begin
            int nBeats;
            nBeats = $urandom_range(1, 4);
            startSession();
            for (int b = 0; b < nBeats; b++) begin
                int k;
                int rs;
                int rt;
                int rd;
                int imm;
                int tgt;
                if (modelCount < DEPTH && $urandom_range(0, 5) == 0) k = $urandom_range(12, 15);
                else k = $urandom_range(0, 11);
                rs  = $urandom_range(0, 31);
                rt  = $urandom_range(0, 31);
                rd  = $urandom_range(0, 31);
                imm = $urandom_range(0, 65535);
                tgt = $urandom_range(0, 32'h3FFFFFF);
                modelBeat(k, rs, rt, rd, imm, tgt);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sendBeat(4'(k), 5'(rs), 5'(rt), 5'(rd), 16'(imm), 26'(tgt), b == nBeats - 1);
            end
            waitDone();
            check($sformatf("rand%0d_count", s), 64'(count), 64'(modelCount));
            check($sformatf("rand%0d_err", s), 64'(err), 64'(modelErr));
            @(negedge clk);
            check($sformatf("rand%0d_writes_left", s), 64'(exp_q.size()), 64'd0);
        end

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
